sd_cmd_rx: RTL

- Host-side receiver for SD card responses on the CMD line.
- Samples CMD on the sd_clk sample strobe and assembles a 48-bit (R1/R3/R6/R7) or 136-bit (R2) response frame.
- Checks CRC7, framing and the N_CR response timeout, then reports status to the command controller.
- Sits between the SD clock generator (which supplies the sample strobe) and the command sequencer (which arms it after transmitting a command).

---
 rtl/sd_cmd_rx.sv | 123 ++++++++++++
 1 files changed

// File: rtl/sd_cmd_rx.sv
// SD host CMD-line response receiver: waits for a start bit within N_CR strobes,
// shifts in a 48- or 136-bit frame and reports CRC7, framing and timeout status.
module sd_cmd_rx #(
    parameter int NCR_MAX = 64
) (
    input  logic         clk,
    input  logic         res,
    input  logic         sd_clk_rise,
    input  logic         cmd_in,
    input  logic         start,
    input  logic         long_resp,
    input  logic         check_crc,
    output logic         busy,
    output logic         done,
    output logic [135:0] resp,
    output logic         crc_err,
    output logic         frame_err,
    output logic         timeout_err
);

    typedef enum logic [1:0] {IDLE, WAIT_START, RECV, DONE} state_t;

    localparam logic [7:0] NCR_LAST = 8'(NCR_MAX - 1);

    state_t       state;
    logic [7:0]   ncr_cnt;
    logic [7:0]   bit_cnt;
    logic [6:0]   crc;
    logic         long_q;
    logic         check_q;

    logic [135:0] resp_shift;
    logic [7:0]   bit_next;
    logic [7:0]   frame_len;
    logic         crc_cover;
    logic         crc_fb;
    logic [6:0]   crc_next;
    logic         trans_bit;

    assign resp_shift = {resp[134:0], cmd_in};
    assign bit_next   = bit_cnt + 8'd1;
    assign frame_len  = long_q ? 8'd136 : 8'd48;
    // R2 frames exclude the start, transmission and reserved header bits from the CRC.
    assign crc_cover  = long_q ? (bit_next >= 8'd9 && bit_next <= 8'd128)
                               : (bit_next <= 8'd40);
    assign crc_fb     = crc[6] ^ cmd_in;
    assign crc_next   = {crc[5:3], crc[2] ^ crc_fb, crc[1:0], crc_fb};
    assign trans_bit  = long_q ? resp_shift[134] : resp_shift[46];

    // NOTE: every register here is written with <= so all updates see pre-edge values.
    always_ff @(posedge clk) begin
        if (res) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            resp        <= '0;
            crc_err     <= 1'b0;
            frame_err   <= 1'b0;
            timeout_err <= 1'b0;
            ncr_cnt     <= '0;
            bit_cnt     <= '0;
            crc         <= '0;
            long_q      <= 1'b0;
            check_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state       <= WAIT_START;
                        busy        <= 1'b1;
                        long_q      <= long_resp;
                        check_q     <= check_crc;
                        resp        <= '0;
                        crc_err     <= 1'b0;
                        frame_err   <= 1'b0;
                        timeout_err <= 1'b0;
                        ncr_cnt     <= '0;
                        bit_cnt     <= '0;
                        crc         <= '0;
                    end
                end
                WAIT_START: begin
                    if (sd_clk_rise) begin
                        if (!cmd_in) begin
                            resp    <= resp_shift;
                            bit_cnt <= 8'd1;
                            if (!long_q) crc <= crc_next;
                            state   <= RECV;
                        end else if (ncr_cnt == NCR_LAST) begin
                            timeout_err <= 1'b1;
                            done        <= 1'b1;
                            state       <= DONE;
                        end else begin
                            ncr_cnt <= ncr_cnt + 8'd1;
                        end
                    end
                end
                RECV: begin
                    if (sd_clk_rise) begin
                        resp    <= resp_shift;
                        bit_cnt <= bit_next;
                        if (crc_cover) crc <= crc_next;
                        if (bit_next == frame_len) begin
                            // resp[6:0] still holds frame bits 7..1 before this final shift.
                            crc_err   <= check_q && (crc != resp[6:0]);
                            frame_err <= trans_bit || !cmd_in;
                            done      <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
